framebuffer_writer: RTL and testbench

Consumes the per-pixel output stream of the raytracing controller (valid, x, y, 16-bit colour) and writes each pixel into a double-buffered frame buffer RAM. It absorbs short write-port stalls with a small FIFO. It counts written pixels and swaps front/back banks when a full frame has landed, so the video scan-out always reads a complete frame. It sits between the raytracing controller and the frame-buffer BRAM write port.

---
 rtl/framebuffer_writer.sv | 157 +++++++++++++++
 tb/tb_framebuffer_writer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_writer.sv
// rtl/framebuffer_writer.sv - pixel stream to double-buffered frame buffer writer
//
// Purpose: takes (x, y, colour) pixels, buffers them in a small FIFO, converts
// the coordinate into a linear address in the back bank and writes it to the
// frame-buffer RAM. After a full frame of completed writes the banks swap.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   frame_start              pulse: begin or restart a frame
//   pixel_valid/x/y/value    incoming pixel; pixel_ready accepts it
//   fb_stall                 RAM write port busy
//   fb_we/fb_addr/fb_data    RAM write port
//   front_bank               bank currently shown by scan-out
//   frame_done               pulse after the last write of a frame
//   busy                     not idle
//   overflow, coord_error    sticky status, cleared by reset or frame_start
module framebuffer_writer #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 180,
  parameter int X_WIDTH       = 9,
  parameter int Y_WIDTH       = 8,
  parameter int IDX_WIDTH     = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 pixel_valid,
  input  logic [X_WIDTH-1:0]   pixel_x,
  input  logic [Y_WIDTH-1:0]   pixel_y,
  input  logic [15:0]          pixel_value,
  output logic                 pixel_ready,
  input  logic                 fb_stall,
  output logic                 fb_we,
  output logic [IDX_WIDTH:0]   fb_addr,
  output logic [15:0]          fb_data,
  output logic                 front_bank,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 overflow,
  output logic                 coord_error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [IDX_WIDTH:0] TOTAL     = (IDX_WIDTH+1)'(SCREEN_WIDTH * SCREEN_HEIGHT);
  localparam logic [X_WIDTH:0]   X_LIM     = (X_WIDTH+1)'(SCREEN_WIDTH);
  localparam logic [Y_WIDTH:0]   Y_LIM     = (Y_WIDTH+1)'(SCREEN_HEIGHT);
  localparam logic [PTR_W:0]     FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t               r_state;
  logic [X_WIDTH-1:0]   r_mem_x [FIFO_DEPTH];
  logic [Y_WIDTH-1:0]   r_mem_y [FIFO_DEPTH];
  logic [15:0]          r_mem_v [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W:0]       r_fifo_cnt;
  logic [IDX_WIDTH:0]   r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_oob;
  logic                 w_push;
  logic                 w_complete;
  logic [IDX_WIDTH:0]   w_count_next;
  logic                 w_last;
  logic                 w_pop;
  logic [IDX_WIDTH-1:0] w_idx;

  assign w_full       = (r_fifo_cnt == FIFO_FULL);
  assign w_empty      = (r_fifo_cnt == '0);
  assign pixel_ready  = (r_state == S_ACTIVE) && !w_full;
  assign busy         = (r_state != S_IDLE);
  assign w_oob        = ({1'b0, pixel_x} >= X_LIM) || ({1'b0, pixel_y} >= Y_LIM);
  // Out-of-range pixels are handshaken but never enter the FIFO.
  assign w_push       = pixel_valid && pixel_ready && !w_oob;
  assign w_complete   = fb_we && !fb_stall;
  assign w_count_next = r_count + (IDX_WIDTH+1)'(1);
  assign w_last       = w_complete && (w_count_next == TOTAL);
  // No refill on the frame's final write: the output register must be empty
  // by the time the banks swap.
  assign w_pop        = (r_state == S_ACTIVE) && !frame_start && !w_empty &&
                        (!fb_we || w_complete) && !w_last;
  assign w_idx        = IDX_WIDTH'(r_mem_y[r_rd_ptr]) * IDX_WIDTH'(SCREEN_WIDTH) +
                        IDX_WIDTH'(r_mem_x[r_rd_ptr]);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_x[r_wr_ptr] <= pixel_x;
      r_mem_y[r_wr_ptr] <= pixel_y;
      r_mem_v[r_wr_ptr] <= pixel_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_cnt  <= '0;
      r_count     <= '0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_data     <= '0;
      front_bank  <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      coord_error <= 1'b0;
    end else if (frame_start) begin
      // Start or abort: everything in flight is flushed, banks untouched.
      r_state     <= S_ACTIVE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_cnt  <= '0;
      r_count     <= '0;
      fb_we       <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      coord_error <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pixel_valid && !pixel_ready) overflow <= 1'b1;
      if (pixel_valid && pixel_ready && w_oob) coord_error <= 1'b1;
      case (r_state)
        S_ACTIVE: begin
          if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
          if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + (PTR_W+1)'(1);
          else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - (PTR_W+1)'(1);
          if (w_pop) begin
            fb_we   <= 1'b1;
            fb_addr <= {~front_bank, w_idx};
            fb_data <= r_mem_v[r_rd_ptr];
          end else if (w_complete) begin
            fb_we <= 1'b0;
          end
          if (w_complete) r_count <= w_count_next;
          if (w_last) begin
            r_state    <= S_DRAIN;
            frame_done <= 1'b1;
            front_bank <= ~front_bank;
          end
        end
        S_DRAIN: begin
          if (!w_empty) overflow <= 1'b1;
          r_wr_ptr   <= '0;
          r_rd_ptr   <= '0;
          r_fifo_cnt <= '0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// tb/tb_framebuffer_writer.sv - scoreboard bench for framebuffer_writer
module tb_framebuffer_writer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int XW = 3;
  localparam int YW = 2;
  localparam int IW = 3;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [XW-1:0] pixel_x = '0;
  logic [YW-1:0] pixel_y = '0;
  logic [15:0]   pixel_value = '0;
  logic          pixel_ready;
  logic          fb_stall = 1'b0;
  logic          fb_we;
  logic [IW:0]   fb_addr;
  logic [15:0]   fb_data;
  logic          front_bank;
  logic          frame_done;
  logic          busy;
  logic          overflow;
  logic          coord_error;

  framebuffer_writer #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .X_WIDTH(XW), .Y_WIDTH(YW),
    .IDX_WIDTH(IW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_value(pixel_value),
    .pixel_ready(pixel_ready), .fb_stall(fb_stall), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .front_bank(front_bank),
    .frame_done(frame_done), .busy(busy), .overflow(overflow),
    .coord_error(coord_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [IW+16:0] exp_q[$];
  logic           exp_front = 1'b0;
  int             n_writes = 0;
  int             n_done = 0;
  int             first_wr_cyc = -1;
  int             last_wr_cyc = -1;
  int             first_acc_cyc = -1;
  logic           hold_valid = 1'b0;
  logic [IW:0]    hold_addr;
  logic [15:0]    hold_data;

  // Scoreboard: every completed write must match the oldest accepted pixel.
  always @(negedge clk) begin
    logic [IW+16:0] e;
    if (rst && hold_valid) begin
      checks++;
      assert (fb_we === 1'b1 && fb_addr === hold_addr && fb_data === hold_data)
      else begin
        errors++;
        $error("FAIL stall_hold we %b addr %h data %h expected we 1 addr %h data %h",
               fb_we, fb_addr, fb_data, hold_addr, hold_data);
      end
    end
    hold_valid = rst && fb_we && fb_stall;
    hold_addr  = fb_addr;
    hold_data  = fb_data;
    if (rst && fb_we && !fb_stall) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_write observed addr %h data %h expected no write", fb_addr, fb_data);
      end else begin
        e = exp_q.pop_front();
        assert ({fb_addr, fb_data} === e)
        else begin
          errors++;
          $error("FAIL write_data observed %h expected %h", {fb_addr, fb_data}, e);
        end
      end
      n_writes++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
    end
    if (rst && frame_done === 1'b1) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Holds the pixel valid until accepted; accepted in-range pixels go to the scoreboard.
  task automatic send(input int x, input int y, input int val);
    int   tries = 0;
    logic acc = 1'b0;
    pixel_valid = 1'b1;
    pixel_x     = XW'(x);
    pixel_y     = YW'(y);
    pixel_value = 16'(val);
    while (!acc && tries < 40) begin
      @(negedge clk);
      if (pixel_ready) begin
        acc = 1'b1;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        if (x < W && y < H) exp_q.push_back({~exp_front, IW'(y * W + x), 16'(val)});
      end
      tick();
      tries++;
    end
    pixel_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < W * H; i++) send(i % W, i / W, base + i);
  endtask

  task automatic wait_done(input string tag);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      seen = (frame_done === 1'b1);
      n++;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      exp_front = ~exp_front;
      check({tag, "_after_last_write"}, 32'(cyc), 32'(last_wr_cyc + 1));
      check({tag, "_front_bank"}, 32'(front_bank), 32'(exp_front));
      check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
    end
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(pixel_ready), 32'd0);
    check({tag, "_we"}, 32'(fb_we), 32'd0);
    check({tag, "_addr"}, 32'(fb_addr), 32'd0);
    check({tag, "_data"}, 32'(fb_data), 32'd0);
    check({tag, "_front"}, 32'(front_bank), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_coord"}, 32'(coord_error), 32'd0);
  endtask

  initial begin
    int snap_w;
    int snap_d;
    int n;

    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Frame 1: latency, throughput, addressing into bank 1
    pulse_start();
    @(negedge clk);
    check("f1_busy_after_start", 32'(busy), 32'd1);
    tick();
    first_acc_cyc = -1;
    first_wr_cyc  = -1;
    send_frame(16'h1000);
    wait_done("f1");
    check("f1_latency", 32'(first_wr_cyc - first_acc_cyc), 32'd2);
    check("f1_consecutive", 32'(last_wr_cyc - first_wr_cyc), 32'd7);
    check("f1_overflow", 32'(overflow), 32'd0);

    // Frame 2: back bank is now 0, front returns to 0
    pulse_start();
    send_frame(16'h1000);
    wait_done("f2");

    // Frame 3: write-port stall with continuous valid
    pulse_start();
    fork
      send_frame(16'h2000);
      begin
        repeat (4) tick();
        fb_stall = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check("stall_ready_low", 32'(pixel_ready), 32'd0);
        check("stall_overflow", 32'(overflow), 32'd1);
        tick();
        fb_stall = 1'b0;
      end
    join
    wait_done("f3");
    check("f3_overflow_sticky", 32'(overflow), 32'd1);

    // Frame 4: out-of-range coordinates dropped
    pulse_start();
    check("f4_overflow_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) send(i % W, i / W, 16'h3000 + i);
    send(4, 0, 16'hBAD0);
    send(0, 2, 16'hBAD1);
    @(negedge clk);
    check("f4_coord_error", 32'(coord_error), 32'd1);
    tick();
    for (int i = 4; i < 8; i++) send(i % W, i / W, 16'h3000 + i);
    wait_done("f4");
    check("f4_coord_sticky", 32'(coord_error), 32'd1);
    check("f4_overflow", 32'(overflow), 32'd0);

    // Frame 5: abort after five writes, then a full frame
    pulse_start();
    snap_w = n_writes;
    for (int i = 0; i < 5; i++) send(i % W, i / W, 16'h4000 + i);
    n = 0;
    while (n_writes < snap_w + 5 && n < 40) begin
      tick();
      n++;
    end
    check("abort_five_writes", 32'(n_writes - snap_w), 32'd5);
    snap_d = n_done;
    pulse_start();
    repeat (3) tick();
    check("abort_no_done", 32'(n_done), 32'(snap_d));
    check("abort_front_kept", 32'(front_bank), 32'(exp_front));
    check("abort_coord_cleared", 32'(coord_error), 32'd0);
    send_frame(16'h5000);
    wait_done("f5");
    check("f5_single_done", 32'(n_done), 32'(snap_d + 1));

    // Pixel while idle
    snap_w = n_writes;
    pixel_valid = 1'b1;
    pixel_x = '0;
    pixel_y = '0;
    pixel_value = 16'h7777;
    @(negedge clk);
    check("idle_ready", 32'(pixel_ready), 32'd0);
    tick();
    pixel_valid = 1'b0;
    @(negedge clk);
    check("idle_overflow", 32'(overflow), 32'd1);
    repeat (3) tick();
    check("idle_no_write", 32'(n_writes), 32'(snap_w));

    // Reset in the middle of a frame
    pulse_start();
    for (int i = 0; i < 3; i++) send(i % W, i / W, 16'h6000 + i);
    rst = 1'b0;
    tick();
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_front = 1'b0;
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
